up_down_ctr: RTL and testbench

Synchronous binary up/down counter, WIDTH bits wide (default 4), clocked by `CLK`. It counts up or down one step per clock according to the `mode` input and exposes a terminal-count flag. It is a general-purpose leaf block for sequencing, timing and demo datapaths. By default it wraps at the ends of its range; a compile-time option makes it saturate instead.

---
 rtl/up_down_ctr.sv | 73 +++++++
 tb/tb_up_down_ctr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/up_down_ctr.sv
// up_down_ctr: synchronous WIDTH-bit binary up/down counter with terminal-count flag.
// The count steps once per CLK edge: up when mode=1, down when mode=0.
// Reset is synchronous and active-low, and it takes priority over counting.
// Optional build macro UP_DOWN_CTR_SATURATE_EN: when defined, the counter holds at
// the ends of its range. When undefined (default), it wraps modulo 2^WIDTH.
module up_down_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_top;
  logic             at_bot;

  // One modular step in the requested direction; carry/borrow is dropped.
  function automatic logic [WIDTH-1:0] step_wrap(input logic [WIDTH-1:0] cur,
                                                 input logic             up);
    logic [WIDTH-1:0] nxt;
    if (up) nxt = cur + ONE;
    else    nxt = cur - ONE;
    return nxt;
  endfunction

  // Clamp a step at the range ends: hold at the end reached in the current direction.
  function automatic logic [WIDTH-1:0] step_sat(input logic [WIDTH-1:0] cur,
                                                input logic             up);
    logic [WIDTH-1:0] nxt;
    if (up && (cur == ALL_ONES))       nxt = cur;
    else if (!up && (cur == ZERO))     nxt = cur;
    else                               nxt = step_wrap(cur, up);
    return nxt;
  endfunction

  // End-of-range detection shared by tc and (optionally) saturation.
  always_comb begin
    at_top = (cnt_q == ALL_ONES);
    at_bot = (cnt_q == ZERO);
  end

  // Next-state: a step in the direction of mode, wrapping or saturating by build.
  always_comb begin
    cnt_d = cnt_q;
`ifdef UP_DOWN_CTR_SATURATE_EN
    cnt_d = step_sat(cnt_q, mode);
`else
    cnt_d = step_wrap(cnt_q, mode);
`endif
  end

  // Count register; synchronous active-low reset wins over counting.
  always_ff @(posedge CLK) begin
    if (!Reset) cnt_q <= ZERO;
    else        cnt_q <= cnt_d;
  end

  // Terminal count follows mode combinationally, so a direction flip shows at once.
  always_comb begin
    tc = mode ? at_top : at_bot;
  end

  assign Q = cnt_q;

endmodule

// File: tb/tb_up_down_ctr.sv
// tb_up_down_ctr: vector table, hand-written corner sequences, and a randomized
// run against a behavioural model for up_down_ctr at WIDTH=4.
module tb_up_down_ctr;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         CLK;
  logic         Reset;
  logic         mode;
  logic [W-1:0] Q;
  logic         tc;

  int checks;
  int failures;

  up_down_ctr #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .mode  (mode),
    .Q     (Q),
    .tc    (tc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Runaway guard.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  typedef struct {
    logic rst_n;
    logic md;
    int   exp_q;
    logic exp_tc;
  } vec_t;

  vec_t vecs[$];

  `ifdef UP_DOWN_CTR_SATURATE_EN
  localparam bit SAT = 1'b1;
  `else
  localparam bit SAT = 1'b0;
  `endif

  task automatic add_vec(input logic r, input logic m, input int q, input logic t);
    vec_t v;
    v.rst_n = r; v.md = m; v.exp_q = q; v.exp_tc = t;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply inputs just after an edge, then advance one edge and settle.
  task automatic edge_step(input logic r, input logic m);
    Reset = r;
    mode  = m;
    @(posedge CLK);
    #1;
  endtask

  // Reset then count up n steps, leaving Q = n.
  task automatic go_to(input int n);
    edge_step(1'b0, 1'b1);
    repeat (n) edge_step(1'b1, 1'b1);
  endtask

  // Behavioural model: the count as an integer in [0, MAXV].
  int model_q;

  function automatic int model_next(input int cur, input logic r, input logic m);
    int n;
    if (!r) return 0;
    if (m) n = cur + 1;
    else   n = cur - 1;
    if (SAT) begin
      if (n > MAXV) n = MAXV;
      if (n < 0)    n = 0;
    end else begin
      n = (n + MAXV + 1) % (MAXV + 1);
    end
    return n;
  endfunction

  function automatic logic model_tc(input int cur, input logic m);
    return m ? (cur == MAXV) : (cur == 0);
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b0;
    mode     = 1'b1;
    #1;

    // ---- vector table ----
    add_vec(1'b0, 1'b1, 0, 1'b0);
    add_vec(1'b0, 1'b1, 0, 1'b0);
    for (int i = 1; i <= MAXV; i++) add_vec(1'b1, 1'b1, i, (i == MAXV));
    if (SAT) begin
      add_vec(1'b1, 1'b1, MAXV, 1'b1);
      add_vec(1'b1, 1'b1, MAXV, 1'b1);
    end else begin
      add_vec(1'b1, 1'b1, 0, 1'b0);
      add_vec(1'b1, 1'b1, 1, 1'b0);
    end
    add_vec(1'b0, 1'b1, 0, 1'b0);
    add_vec(1'b1, 1'b1, 1, 1'b0);
    add_vec(1'b1, 1'b1, 2, 1'b0);
    add_vec(1'b1, 1'b0, 1, 1'b0);
    add_vec(1'b1, 1'b0, 0, 1'b1);
    if (SAT) begin
      add_vec(1'b1, 1'b0, 0, 1'b1);
      add_vec(1'b1, 1'b0, 0, 1'b1);
    end else begin
      add_vec(1'b1, 1'b0, MAXV, 1'b0);
      add_vec(1'b1, 1'b0, MAXV - 1, 1'b0);
    end

    foreach (vecs[i]) begin
      edge_step(vecs[i].rst_n, vecs[i].md);
      chk($sformatf("vec%0d_q", i), 32'(Q), 32'(vecs[i].exp_q));
      chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
    end

    // ---- direction switch: 5 -> 4 -> 5 ----
    go_to(5);
    chk("dir_at5", 32'(Q), 32'd5);
    #2 mode = 1'b0;
    @(posedge CLK); #1;
    chk("dir_down_q", 32'(Q), 32'd4);
    edge_step(1'b1, 1'b1);
    chk("dir_up_q", 32'(Q), 32'd5);

    // ---- mid-count reset, then up ----
    go_to(9);
    Reset = 1'b0;
    #3;
    chk("mrst_hold_q", 32'(Q), 32'd9);
    @(posedge CLK); #1;
    chk("mrst_clear_q", 32'(Q), 32'd0);
    edge_step(1'b1, 1'b1);
    chk("mrst_up_q", 32'(Q), 32'd1);

    // ---- mid-count reset, then down ----
    go_to(9);
    edge_step(1'b0, 1'b0);
    chk("mrst2_clear_q", 32'(Q), 32'd0);
    edge_step(1'b1, 1'b0);
    chk("mrst2_down_q", 32'(Q), SAT ? 32'd0 : 32'(MAXV));

    // ---- tc reacts to mode between edges ----
    edge_step(1'b0, 1'b1);
    Reset = 1'b1;
    #1;
    chk("tcc_up_tc", 32'(tc), 32'd0);
    mode = 1'b0;
    #1;
    chk("tcc_down_tc", 32'(tc), 32'd1);
    chk("tcc_q_same", 32'(Q), 32'd0);
    mode = 1'b1;
    #1;
    chk("tcc_back_tc", 32'(tc), 32'd0);

    // ---- randomized run against the model ----
    edge_step(1'b0, 1'b1);
    model_q = 0;
    for (int i = 0; i < 400; i++) begin
      logic r, m;
      r = ($urandom_range(0, 15) != 0);
      m = ($urandom_range(0, 3) != 0) ^ (i >= 200);
      edge_step(r, m);
      model_q = model_next(model_q, r, m);
      chk($sformatf("rnd%0d_q", i), 32'(Q), 32'(model_q));
      chk($sformatf("rnd%0d_tc", i), 32'(tc), 32'(model_tc(model_q, m)));
      // Flip mode between edges and confirm tc follows immediately.
      if ((i % 7) == 3) begin
        mode = ~m;
        #1;
        chk($sformatf("rnd%0d_tcflip", i), 32'(tc), 32'(model_tc(model_q, ~m)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
